// File: rtl/batcharger_mode_fsm.sv
// Charge-phase controller for the Li-ion charger: selects TC/CC/CV/DONE/FAULT and drives setpoints.
// Optional CV duration limit enabled by defining BATCHARGER_CV_TIMEOUT_EN.
module batcharger_mode_fsm #(
    parameter int VPRESET   = 150,
    parameter int VCUTOFF   = 210,
    parameter int VRECHARGE = 200,
    parameter int TEMPMIN   = 47,
    parameter int TEMPMAX   = 140,
    parameter int DEBOUNCE  = 4
`ifdef BATCHARGER_CV_TIMEOUT_EN
    ,parameter int TCVMAX   = 4096
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sel,
    input  logic       smp_valid,
    input  logic [7:0] vbat_code,
    input  logic [7:0] ibat_code,
    input  logic [7:0] vtemp_code,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic       done,
    output logic       fault,
    output logic [7:0] itarget,
    output logic [7:0] vtarget
);

    // state   | meaning
    // S_IDLE  | charger disabled, all outputs 0
    // S_TC    | trickle charge at C/10
    // S_CC    | constant current at 1C
    // S_CV    | constant voltage, current tapering
    // S_DONE  | charge complete, waiting for recharge threshold
    // S_FAULT | temperature outside safe window
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TC    = 3'd1;
    localparam logic [2:0] S_CC    = 3'd2;
    localparam logic [2:0] S_CV    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    logic [2:0] state, nxt_state;
    logic [3:0] sel_l, sel_nxt;
    logic [3:0] db_cnt, db_nxt;
    logic [3:0] tmp_cnt, tmp_nxt;
    logic       temp_bad, exit_cond, tmp_watch, db_hit, tmp_hit, cv_to;
    logic [7:0] i_c10, i_1c;

    always_comb begin
        temp_bad = (vtemp_code < 8'(TEMPMIN)) || (vtemp_code > 8'(TEMPMAX));
        case (state)
            S_TC:    exit_cond = vbat_code >= 8'(VPRESET);
            S_CC:    exit_cond = vbat_code >= 8'(VCUTOFF);
            S_CV:    exit_cond = ibat_code < ({4'd0, sel_l} + 8'd1);
            S_DONE:  exit_cond = vbat_code < 8'(VRECHARGE);
            S_FAULT: exit_cond = !temp_bad;
            default: exit_cond = 1'b0;
        endcase
        tmp_watch = (state == S_TC) || (state == S_CC) || (state == S_CV) || (state == S_DONE);
        db_hit    = smp_valid && exit_cond && (db_cnt == DB_LAST);
        tmp_hit   = smp_valid && tmp_watch && temp_bad && (tmp_cnt == DB_LAST);
    end

`ifdef BATCHARGER_CV_TIMEOUT_EN
    logic [15:0] cv_cnt, cv_nxt;

    assign cv_to = smp_valid && (state == S_CV) && (cv_cnt >= 16'(TCVMAX - 1));

    always_comb begin
        cv_nxt = 16'd0;
        if ((state == S_CV) && (nxt_state == S_CV))
            cv_nxt = (smp_valid && (cv_cnt != 16'hFFFF)) ? cv_cnt + 16'd1 : cv_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cv_cnt <= 16'd0;
        else     cv_cnt <= cv_nxt;
    end
`else
    assign cv_to = 1'b0;
`endif

    always_comb begin
        nxt_state = state;
        sel_nxt   = sel_l;
        db_nxt    = db_cnt;
        tmp_nxt   = tmp_cnt;
        if (smp_valid) begin
            db_nxt  = exit_cond ? db_cnt + 4'd1 : 4'd0;
            tmp_nxt = (tmp_watch && temp_bad) ? tmp_cnt + 4'd1 : 4'd0;
        end
        if (!en) begin
            nxt_state = S_IDLE;
        end else if (state == S_IDLE) begin
            nxt_state = S_TC;
            sel_nxt   = sel;
        end else if (tmp_hit) begin
            nxt_state = S_FAULT;
        end else if (db_hit || cv_to) begin
            case (state)
                S_TC:    nxt_state = S_CC;
                S_CC:    nxt_state = S_CV;
                S_CV:    nxt_state = S_DONE;
                S_DONE:  nxt_state = S_TC;
                S_FAULT: nxt_state = S_TC;
                default: nxt_state = S_IDLE;
            endcase
        end
        // Any phase change or disable restarts both debounce windows.
        if (!en || (nxt_state != state)) begin
            db_nxt  = 4'd0;
            tmp_nxt = 4'd0;
        end
        i_c10 = {4'd0, sel_nxt} + 8'd1;
        i_1c  = i_c10 * 8'd10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sel_l   <= 4'd0;
            db_cnt  <= 4'd0;
            tmp_cnt <= 4'd0;
            tc      <= 1'b0;
            cc      <= 1'b0;
            cv      <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            itarget <= 8'd0;
            vtarget <= 8'd0;
        end else begin
            state   <= nxt_state;
            sel_l   <= sel_nxt;
            db_cnt  <= db_nxt;
            tmp_cnt <= tmp_nxt;
            tc      <= (nxt_state == S_TC);
            cc      <= (nxt_state == S_CC);
            cv      <= (nxt_state == S_CV);
            done    <= (nxt_state == S_DONE);
            fault   <= (nxt_state == S_FAULT);
            case (nxt_state)
                S_TC:       itarget <= i_c10;
                S_CC, S_CV: itarget <= i_1c;
                default:    itarget <= 8'd0;
            endcase
            vtarget <= ((nxt_state == S_TC) || (nxt_state == S_CC) || (nxt_state == S_CV))
                       ? 8'(VCUTOFF) : 8'd0;
        end
    end

endmodule

// File: tb/tb_batcharger_mode_fsm.sv
// Bench for batcharger_mode_fsm: directed vector table, CV corner sequence, randomized run vs phase model.
module tb_batcharger_mode_fsm;

    localparam int DB = 4;
`ifdef BATCHARGER_CV_TIMEOUT_EN
    localparam int TCV = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] sel = 4'd0;
    logic       smp_valid = 1'b0;
    logic [7:0] vbat_code = 8'd0;
    logic [7:0] ibat_code = 8'd0;
    logic [7:0] vtemp_code = 8'd100;
    logic       tc, cc, cv, done, fault;
    logic [7:0] itarget, vtarget;

    always #5 clk = ~clk;

`ifdef BATCHARGER_CV_TIMEOUT_EN
    batcharger_mode_fsm #(.TCVMAX(TCV)) dut (
`else
    batcharger_mode_fsm dut (
`endif
        .clk(clk), .rst(rst), .en(en), .sel(sel), .smp_valid(smp_valid),
        .vbat_code(vbat_code), .ibat_code(ibat_code), .vtemp_code(vtemp_code),
        .tc(tc), .cc(cc), .cv(cv), .done(done), .fault(fault),
        .itarget(itarget), .vtarget(vtarget));

    typedef enum int {P_FAULT, P_DONE, P_IDLE, P_CV, P_TC, P_CC} phase_t;

    typedef struct {
        bit     en;
        int     sel;
        bit     smp;
        int     vb;
        int     ib;
        int     vt;
        phase_t ph;
        int     it;
        int     vtg;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    phase_t m_ph;
    int     m_sl, m_run, m_trun, m_cvs;

    function automatic logic [31:0] bundle(phase_t p, int it, int vtg);
        logic [4:0] f;
        f = {p == P_TC, p == P_CC, p == P_CV, p == P_DONE, p == P_FAULT};
        return {11'd0, f, it[7:0], vtg[7:0]};
    endfunction

    function automatic logic [31:0] model_bundle();
        int it, vtg;
        it  = 0;
        vtg = 0;
        if (m_ph == P_TC) it = m_sl + 1;
        if (m_ph == P_CC || m_ph == P_CV) it = 10 * (m_sl + 1);
        if (m_ph == P_TC || m_ph == P_CC || m_ph == P_CV) vtg = 210;
        return bundle(m_ph, it, vtg);
    endfunction

    function automatic logic [31:0] dut_bundle();
        return {11'd0, tc, cc, cv, done, fault, itarget, vtarget};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_sl = 0; m_run = 0; m_trun = 0; m_cvs = 0;
    endtask

    // Advances the reference by one clock using the inputs currently applied.
    task automatic model_step();
        bit     bad, cond;
        phase_t nx;
        int     v, i, t;
        v = int'(vbat_code); i = int'(ibat_code); t = int'(vtemp_code);
        nx = m_ph;
        if (!en) begin
            nx = P_IDLE;
        end else if (m_ph == P_IDLE) begin
            nx = P_TC;
            m_sl = int'(sel);
        end else if (smp_valid) begin
            bad = (t < 47) || (t > 140);
            case (m_ph)
                P_TC:    cond = v >= 150;
                P_CC:    cond = v >= 210;
                P_CV:    cond = i < m_sl + 1;
                P_DONE:  cond = v < 200;
                default: cond = !bad;
            endcase
            m_trun = (bad && m_ph != P_FAULT) ? m_trun + 1 : 0;
            m_run  = cond ? m_run + 1 : 0;
            if (m_ph == P_CV) m_cvs++;
            if (m_trun >= DB) nx = P_FAULT;
            else if (m_run >= DB) begin
                case (m_ph)
                    P_TC:    nx = P_CC;
                    P_CC:    nx = P_CV;
                    P_CV:    nx = P_DONE;
                    default: nx = P_TC;
                endcase
            end
`ifdef BATCHARGER_CV_TIMEOUT_EN
            else if (m_ph == P_CV && m_cvs >= TCV) nx = P_DONE;
`endif
        end
        if (nx != m_ph || !en) begin
            m_run = 0; m_trun = 0; m_cvs = 0;
        end
        m_ph = nx;
    endtask

    task automatic drive(input bit e, input int s, input bit v, input int vb, input int ib, input int vt);
        en = e; sel = 4'(s); smp_valid = v;
        vbat_code = 8'(vb); ibat_code = 8'(ib); vtemp_code = 8'(vt);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc(input string name, input bit e, input int s, input bit v,
                       input int vb, input int ib, input int vt);
        drive(e, s, v, vb, ib, vt);
        chk(name, dut_bundle(), model_bundle());
    endtask

    task automatic add(input bit e, input int s, input bit v, input int vb, input int ib,
                       input int vt, input phase_t ph, input int it, input int vtg, input int n);
        vec_t r;
        r = '{en: e, sel: s, smp: v, vb: vb, ib: ib, vt: vt, ph: ph, it: it, vtg: vtg};
        for (int k = 0; k < n; k++) vecs.push_back(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_reset", dut_bundle(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_state", dut_bundle(), 32'd0);
        rst = 1'b0;

        add(1, 8, 1, 120, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_TC, 9, 210, 3);
        add(1, 8, 1, 149, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_TC, 9, 210, 2);
        add(1, 8, 0,   0, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_CC, 90, 210, 1);
        add(1, 8, 1, 210, 100, 100, P_CC, 90, 210, 3);
        add(1, 8, 1, 210, 100, 100, P_CV, 90, 210, 1);
        add(1, 8, 1, 210,   8, 100, P_CV, 90, 210, 3);
        add(1, 8, 1, 210,   8, 100, P_DONE, 0, 0, 1);
        add(1, 8, 1, 199, 100, 100, P_DONE, 0, 0, 3);
        add(1, 8, 1, 199, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_TC, 9, 210, 3);
        add(1, 8, 1, 150, 100, 100, P_CC, 90, 210, 1);
        add(1, 8, 1, 210, 100, 141, P_CC, 90, 210, 3);
        add(1, 8, 1, 210, 100, 141, P_FAULT, 0, 0, 1);
        add(1, 8, 1, 120, 100, 100, P_FAULT, 0, 0, 3);
        add(1, 8, 1, 120, 100, 100, P_TC, 9, 210, 1);
        add(1, 8, 1, 150, 100, 100, P_TC, 9, 210, 3);
        add(1, 8, 1, 150, 100, 100, P_CC, 90, 210, 1);
        add(1, 0, 1, 150, 100, 100, P_CC, 90, 210, 1);
        add(0, 0, 1, 210, 100, 100, P_IDLE, 0, 0, 1);
        add(1, 0, 0, 120, 100, 100, P_TC, 1, 210, 1);

        foreach (vecs[n]) begin
            drive(vecs[n].en, vecs[n].sel, vecs[n].smp, vecs[n].vb, vecs[n].ib, vecs[n].vt);
            chk($sformatf("vec%0d", n), dut_bundle(), bundle(vecs[n].ph, vecs[n].it, vecs[n].vtg));
            chk($sformatf("vec%0d_model", n), model_bundle(), bundle(vecs[n].ph, vecs[n].it, vecs[n].vtg));
        end

        // Hold CV with a current that never qualifies for DONE.
        for (int k = 0; k < 4; k++) cyc("to_cc", 1, 0, 1, 150, 100, 100);
        for (int k = 0; k < 4; k++) cyc("to_cv", 1, 0, 1, 210, 100, 100);
        chk("cv_entered", {31'd0, cv}, 32'd1);
`ifdef BATCHARGER_CV_TIMEOUT_EN
        for (int k = 0; k < TCV - 1; k++) cyc("cv_hold", 1, 0, 1, 210, 50, 100);
        chk("cv_before_timeout", {31'd0, cv}, 32'd1);
        cyc("cv_hold", 1, 0, 1, 210, 50, 100);
        chk("cv_timeout_done", {31'd0, done}, 32'd1);
`else
        for (int k = 0; k < 100; k++) cyc("cv_hold", 1, 0, 1, 210, 50, 100);
        chk("cv_no_timeout", {31'd0, cv}, 32'd1);
`endif

        for (int k = 0; k < 4000; k++) begin
            int vt, r;
            r = int'($urandom_range(0, 19));
            if (r == 0)      vt = int'($urandom_range(0, 47));
            else if (r == 1) vt = int'($urandom_range(140, 255));
            else             vt = int'($urandom_range(60, 130));
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc("random", $urandom_range(0, 79) != 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 2) != 0, int'($urandom_range(140, 215)),
                int'($urandom_range(0, 30)), vt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
